// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream in, big-endian
// 32-bit word writes out, CPU held in reset until the whole image is written.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       checksum,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] IDX_ONE = 1;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  // Only the first three bytes need storage; the fourth goes straight into the word.
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       cks_q, cks_d;
  logic [15:0]       words_q, words_d;
  logic              accept;

  assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    widx_d  = widx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    cks_d   = cks_q;
    words_d = words_q;
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = ({len_q[15:8], in_data} == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d  = {asm_q[15:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Index MSB set means past the end of memory; it saturates so a long
            // image can never wrap back and overwrite low addresses.
            wdata_d = {asm_q, in_data};
            addr_d  = widx_q[ADDR_W-1:0];
            we_d    = !widx_q[ADDR_W];
            ovf_d   = ovf_q | widx_q[ADDR_W];
            cks_d   = cks_q ^ {asm_q, in_data};
            words_d = words_q + 16'd1;
            widx_d  = widx_q[ADDR_W] ? widx_q : widx_q + IDX_ONE;
            bcnt_d  = '0;
            if (words_d == len_q) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
    done_d = (state_q == S_DONE);
    hold_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cks_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      cks_q   <= cks_d;
      words_q <= words_d;
    end
  end

  assign im_we        = we_q;
  assign im_addr      = addr_q;
  assign im_wdata     = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign checksum     = cks_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-depth instance and a 4-word instance
// share one input stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready, im_we, cpu_hold, done, overflow;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata, checksum;
  logic [15:0] words_loaded;

  logic        s_ready, s_we, s_hold, s_done, s_ovf;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata, s_cks;
  logic [15:0] s_words;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .checksum(checksum), .words_loaded(words_loaded)
  );

  imem_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(s_ready), .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata),
    .cpu_hold(s_hold), .done(s_done), .overflow(s_ovf),
    .checksum(s_cks), .words_loaded(s_words)
  );

  // Write log for both instances, sampled mid-cycle.
  int          big_we_cnt = 0;
  int          small_we_cnt = 0;
  logic [7:0]  big_last_addr;
  logic [31:0] big_last_data;
  logic [1:0]  small_addr [16];
  logic [31:0] small_data [16];

  always @(negedge clk) begin
    if (im_we) begin
      big_we_cnt    <= big_we_cnt + 1;
      big_last_addr <= im_addr;
      big_last_data <= im_wdata;
    end
    if (s_we) begin
      if (small_we_cnt < 16) begin
        small_addr[small_we_cnt] <= s_addr;
        small_data[small_we_cnt] <= s_wdata;
      end
      small_we_cnt <= small_we_cnt + 1;
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        dn;
  } vec_t;

  vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (!done && k < maxc) begin
      tick();
      k++;
    end
    chk("wait_done", done, 1);
  endtask

  int base, sbase;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // N=2 stream, back-to-back: {valid, data, ready before edge, we/addr/wdata/done after edge}
    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 8'h08, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h00, 32'h20080005, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 8'h08, 1'b1, 1'b1, 8'h01, 32'h00000008, 1'b0};
    tbl[10] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1};

    do_reset();
    chk("rst_ready", in_ready, 1);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_wdata", im_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cks", checksum, 0);
    chk("rst_words", words_loaded, 0);

    // Test 1: table-driven N=2 image
    base = big_we_cnt;
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      chk($sformatf("t1_ready[%0d]", i), in_ready, tbl[i].rdy);
      tick();
      chk($sformatf("t1_we[%0d]", i), im_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("t1_addr[%0d]", i), im_addr, tbl[i].addr);
        chk($sformatf("t1_wdata[%0d]", i), im_wdata, tbl[i].wdata);
      end
      chk($sformatf("t1_done[%0d]", i), done, tbl[i].dn);
      chk($sformatf("t1_hold[%0d]", i), cpu_hold, !tbl[i].dn);
    end
    in_valid = 1'b0;
    chk("t1_cks", checksum, 32'h2008000D);
    chk("t1_words", words_loaded, 2);
    chk("t1_wecnt", big_we_cnt - base, 2);

    // Test 2: N=0
    do_reset();
    base = big_we_cnt;
    send(8'h00);
    send(8'h00);
    chk("t2_ready0", in_ready, 0);
    chk("t2_done_early", done, 0);
    chk("t2_hold_early", cpu_hold, 1);
    tick();
    chk("t2_done", done, 1);
    chk("t2_hold", cpu_hold, 0);
    chk("t2_cks", checksum, 0);
    chk("t2_words", words_loaded, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_ready_idle", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("t2_wecnt", big_we_cnt - base, 0);

    // Test 3: N=1 with in_valid toggling
    do_reset();
    base = big_we_cnt;
    send(8'h00); tick();
    send(8'h01); tick();
    send(8'hDE); tick();
    send(8'hAD); tick();
    send(8'hBE); tick();
    chk("t3_ready_stall", in_ready, 1);
    send(8'hEF);
    chk("t3_we", im_we, 1);
    chk("t3_addr", im_addr, 0);
    chk("t3_wdata", im_wdata, 32'hDEADBEEF);
    chk("t3_ready_flush", in_ready, 0);
    chk("t3_done_t1", done, 0);
    chk("t3_cks", checksum, 32'hDEADBEEF);
    chk("t3_words", words_loaded, 1);
    tick();
    chk("t3_we_off", im_we, 0);
    chk("t3_done_t1b", done, 0);
    chk("t3_hold_t1", cpu_hold, 1);
    tick();
    chk("t3_done_t2", done, 1);
    chk("t3_hold_t2", cpu_hold, 0);
    chk("t3_wecnt", big_we_cnt - base, 1);

    // Test 4: N=5 words 1..5, small instance overflows after 4 words
    do_reset();
    base  = big_we_cnt;
    sbase = small_we_cnt;
    send(8'h00);
    send(8'h05);
    for (int w = 1; w <= 5; w++) begin
      send(8'h00); send(8'h00); send(8'h00); send(8'(w));
    end
    tick();
    tick();
    chk("t4_s_wecnt", small_we_cnt - sbase, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t4_s_addr[%0d]", j), small_addr[sbase + j], j);
      chk($sformatf("t4_s_data[%0d]", j), small_data[sbase + j], j + 1);
    end
    chk("t4_s_ovf", s_ovf, 1);
    chk("t4_s_words", s_words, 5);
    chk("t4_s_cks", s_cks, 32'h1);
    chk("t4_s_done", s_done, 1);
    chk("t4_b_ovf", overflow, 0);
    chk("t4_b_wecnt", big_we_cnt - base, 5);
    chk("t4_b_cks", checksum, 32'h1);
    chk("t4_b_last_addr", big_last_addr, 4);

    // Test 5: reset mid-load, then a fresh N=1 image
    do_reset();
    send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
    chk("t5_words_pre", words_loaded, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rst_hold", cpu_hold, 1);
    chk("t5_rst_words", words_loaded, 0);
    chk("t5_rst_cks", checksum, 0);
    chk("t5_rst_ready", in_ready, 1);
    base = big_we_cnt;
    send(8'h00); chk("t5_hold_a", cpu_hold, 1);
    send(8'h01); chk("t5_hold_b", cpu_hold, 1);
    send(8'h12); chk("t5_hold_c", cpu_hold, 1);
    send(8'h34); chk("t5_hold_d", cpu_hold, 1);
    send(8'h56); chk("t5_hold_e", cpu_hold, 1);
    send(8'h78); chk("t5_hold_f", cpu_hold, 1);
    tick();
    chk("t5_hold_g", cpu_hold, 1);
    wait_done(5);
    chk("t5_hold_end", cpu_hold, 0);
    chk("t5_wecnt", big_we_cnt - base, 1);
    chk("t5_addr", big_last_addr, 0);
    chk("t5_data", big_last_data, 32'h12345678);
    chk("t5_words", words_loaded, 1);
    chk("t5_ovf", overflow, 0);
    chk("t5_cks", checksum, 32'h12345678);

    // Test 6: valid held high after done
    base     = big_we_cnt;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_ready", in_ready, 0);
      chk("t6_we", im_we, 0);
      chk("t6_done", done, 1);
    end
    in_valid = 1'b0;
    chk("t6_words", words_loaded, 1);
    chk("t6_wecnt", big_we_cnt - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
